// File: rtl/frame_capture_sched.sv
// frame_capture_sched
// Capture controller between the processed destination video stream and the
// text-file frame store. On command it arms, waits for a fresh frame start,
// forwards whole frames (one-cycle latency), skips a programmable number of
// frames between captures, rotates the 2-bit file select per captured frame
// and checks the geometry of every captured frame.
//
// Ports:
//   dst_pclk, rst_n             pixel clock, async active-low reset
//   cap_start / cap_abort       one-cycle command pulses
//   cap_num, cap_skip, sel_base run parameters, sampled on an accepted cap_start
//   dst_hsync_in/vsync_in/data  incoming video stream
//   st_src_sel/hsync/vsync/data gated stream and file select to the store
//   cap_busy, cap_done          run status (done is a one-cycle pulse)
//   frm_stored, frm_err         frames forwarded this run, sticky geometry flags
//   dbg_state                   current FSM state (IDLE=0 ARM=1 SKIP=2 CAPT=3)
//
// Stream semantics: dst_vsync_in high marks a frame, dst_hsync_in high marks a
// valid pixel; there is no back-pressure, the store accepts every cycle.
module frame_capture_sched #(
  parameter int DST_DW    = 24,
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int FRM_CNT_W = 8
) (
  input  logic                 dst_pclk,
  input  logic                 rst_n,
  input  logic                 cap_start,
  input  logic                 cap_abort,
  input  logic [FRM_CNT_W-1:0] cap_num,
  input  logic [3:0]           cap_skip,
  input  logic [1:0]           sel_base,
  input  logic                 dst_hsync_in,
  input  logic                 dst_vsync_in,
  input  logic [DST_DW-1:0]    dst_data_in,
  output logic [1:0]           st_src_sel,
  output logic                 st_hsync,
  output logic                 st_vsync,
  output logic [DST_DW-1:0]    st_data,
  output logic                 cap_busy,
  output logic                 cap_done,
  output logic [FRM_CNT_W-1:0] frm_stored,
  output logic [1:0]           frm_err,
  output logic [1:0]           dbg_state
);

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_SKIP = 2'd2,
    S_CAPT = 2'd3
  } state_t;

  state_t                 r_state;
  logic                   r_vsync_d;
  logic                   r_hsync_d;
  logic [FRM_CNT_W-1:0]   r_num;
  logic [3:0]             r_skip;
  logic [1:0]             r_base;
  logic [3:0]             r_skip_cnt;
  logic [CNT_W-1:0]       r_pix_cnt;
  logic [CNT_W-1:0]       r_line_cnt;
  logic                   r_abort_pend;
  logic                   r_zero_pend;

  logic                   w_vpos;
  logic                   w_vneg;
  logic                   w_hneg;
  logic [FRM_CNT_W-1:0]   w_stored_inc;
  logic [CNT_W-1:0]       w_line_total;
  logic                   w_pix_ok;
  logic                   w_lines_ok;

  assign w_vpos       = dst_vsync_in & ~r_vsync_d;
  assign w_vneg       = ~dst_vsync_in & r_vsync_d;
  assign w_hneg       = ~dst_hsync_in & r_hsync_d;
  assign w_stored_inc = frm_stored + FRM_CNT_W'(1);
  // A line that ends in the same cycle as the frame still counts.
  assign w_line_total = r_line_cnt + {{(CNT_W-1){1'b0}}, w_hneg};
  assign w_pix_ok     = (r_pix_cnt == CNT_W'(H_ACT));
  assign w_lines_ok   = (w_line_total == CNT_W'(V_ACT));
  assign dbg_state    = r_state;

  always_ff @(posedge dst_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vsync_d    <= 1'b0;
      r_hsync_d    <= 1'b0;
      r_num        <= '0;
      r_skip       <= '0;
      r_base       <= '0;
      r_skip_cnt   <= '0;
      r_pix_cnt    <= '0;
      r_line_cnt   <= '0;
      r_abort_pend <= 1'b0;
      r_zero_pend  <= 1'b0;
      st_src_sel   <= '0;
      st_hsync     <= 1'b0;
      st_vsync     <= 1'b0;
      st_data      <= '0;
      cap_busy     <= 1'b0;
      cap_done     <= 1'b0;
      frm_stored   <= '0;
      frm_err      <= '0;
    end else begin
      r_vsync_d <= dst_vsync_in;
      r_hsync_d <= dst_hsync_in;
      cap_done  <= 1'b0;
      // The store only sees a stream while a frame is being captured.
      st_vsync  <= 1'b0;
      st_hsync  <= 1'b0;
      st_data   <= '0;

      case (r_state)
        S_IDLE: begin
          if (r_zero_pend) begin
            // cap_num=0: the run is over as soon as it starts.
            r_zero_pend <= 1'b0;
            cap_busy    <= 1'b0;
            cap_done    <= 1'b1;
          end else if (cap_start && !cap_abort) begin
            r_num        <= cap_num;
            r_skip       <= cap_skip;
            r_base       <= sel_base;
            cap_busy     <= 1'b1;
            frm_err      <= '0;
            frm_stored   <= '0;
            r_abort_pend <= 1'b0;
            if (cap_num == '0) r_zero_pend <= 1'b1;
            else               r_state     <= S_ARM;
          end
        end

        S_ARM: begin
          if (cap_abort) begin
            r_state  <= S_IDLE;
            cap_busy <= 1'b0;
          end else if (w_vpos) begin
            // Only a rising vsync opens a frame, so a frame already running
            // when the run started is never forwarded.
            r_state    <= S_CAPT;
            st_vsync   <= 1'b1;
            st_hsync   <= dst_hsync_in;
            st_data    <= dst_hsync_in ? dst_data_in : '0;
            st_src_sel <= r_base + frm_stored[1:0];
            r_pix_cnt  <= dst_hsync_in ? CNT_W'(1) : '0;
            r_line_cnt <= '0;
          end
        end

        S_SKIP: begin
          if (cap_abort) begin
            r_state  <= S_IDLE;
            cap_busy <= 1'b0;
          end else if (w_vneg) begin
            if (r_skip_cnt + 4'd1 == r_skip) begin
              r_state    <= S_ARM;
              r_skip_cnt <= '0;
            end else begin
              r_skip_cnt <= r_skip_cnt + 4'd1;
            end
          end
        end

        S_CAPT: begin
          // An abort never cuts a frame; it takes effect at the frame end.
          if (cap_abort) r_abort_pend <= 1'b1;
          if (w_vneg) begin
            frm_stored <= w_stored_inc;
            if (w_hneg && !w_pix_ok) frm_err[0] <= 1'b1;
            if (!w_lines_ok)         frm_err[1] <= 1'b1;
            r_pix_cnt    <= '0;
            r_line_cnt   <= '0;
            r_abort_pend <= 1'b0;
            if (r_abort_pend || cap_abort) begin
              r_state  <= S_IDLE;
              cap_busy <= 1'b0;
            end else if (w_stored_inc == r_num) begin
              r_state  <= S_IDLE;
              cap_busy <= 1'b0;
              cap_done <= 1'b1;
            end else if (r_skip != 4'd0) begin
              r_state    <= S_SKIP;
              r_skip_cnt <= '0;
            end else begin
              r_state <= S_ARM;
            end
          end else begin
            st_vsync <= dst_vsync_in;
            st_hsync <= dst_hsync_in;
            st_data  <= dst_hsync_in ? dst_data_in : '0;
            if (w_hneg) begin
              if (!w_pix_ok) frm_err[0] <= 1'b1;
              r_pix_cnt  <= '0;
              r_line_cnt <= r_line_cnt + CNT_W'(1);
            end else if (dst_hsync_in) begin
              r_pix_cnt <= r_pix_cnt + CNT_W'(1);
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_capture_sched.sv
// Testbench for frame_capture_sched with a small geometry (8x4). A driver
// generates frames on the falling clock edge and pushes the expected store
// events (frame open, pixel, frame close, done) with their expected cycle
// stamps; a monitor on the falling edge pops and compares each event the DUT
// actually presents.
module tb_frame_capture_sched;

  localparam int DW = 24;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int FW = 8;
  localparam int EW = 60;  // {kind[1:0], cycle[31:0], sel[1:0], data[23:0]}

  localparam logic [1:0] K_RISE = 2'd0;
  localparam logic [1:0] K_PIX  = 2'd1;
  localparam logic [1:0] K_FALL = 2'd2;
  localparam logic [1:0] K_DONE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic          cap_start = 1'b0;
  logic          cap_abort = 1'b0;
  logic [FW-1:0] cap_num   = '0;
  logic [3:0]    cap_skip  = '0;
  logic [1:0]    sel_base  = '0;
  logic          hsync     = 1'b0;
  logic          vsync     = 1'b0;
  logic [DW-1:0] data      = '0;
  logic [1:0]    st_src_sel;
  logic          st_hsync;
  logic          st_vsync;
  logic [DW-1:0] st_data;
  logic          cap_busy;
  logic          cap_done;
  logic [FW-1:0] frm_stored;
  logic [1:0]    frm_err;
  logic [1:0]    dbg_state;

  frame_capture_sched #(
    .DST_DW(DW), .H_ACT(H), .V_ACT(V), .FRM_CNT_W(FW)
  ) dut (
    .dst_pclk    (clk),
    .rst_n       (rst_n),
    .cap_start   (cap_start),
    .cap_abort   (cap_abort),
    .cap_num     (cap_num),
    .cap_skip    (cap_skip),
    .sel_base    (sel_base),
    .dst_hsync_in(hsync),
    .dst_vsync_in(vsync),
    .dst_data_in (data),
    .st_src_sel  (st_src_sel),
    .st_hsync    (st_hsync),
    .st_vsync    (st_vsync),
    .st_data     (st_data),
    .cap_busy    (cap_busy),
    .cap_done    (cap_done),
    .frm_stored  (frm_stored),
    .frm_err     (frm_err),
    .dbg_state   (dbg_state)
  );

  // scoreboard
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int frm_id   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  function automatic void push_ev(input logic [1:0] k, input int c, input logic [1:0] s,
                                  input logic [DW-1:0] d);
    exp_q.push_back({k, 32'(c), s, d});
  endfunction

  // monitor
  logic prev_vs = 1'b0;

  task automatic mon_event(input logic [1:0] k, input logic [1:0] s, input logic [DW-1:0] d);
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    act = {k, 32'(cyc), s, d};
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got %h expected none (cycle %0d)", act, cyc);
    end else begin
      exp = exp_q.pop_front();
      check("store_event", 64'(act), 64'(exp));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (st_vsync && !prev_vs) mon_event(K_RISE, st_src_sel, st_data);
      if (st_hsync)             mon_event(K_PIX, st_src_sel, st_data);
      if (!st_vsync && prev_vs) mon_event(K_FALL, st_src_sel, st_data);
      if (cap_done)             mon_event(K_DONE, 2'd0, '0);
    end
    prev_vs = st_vsync;
  end

  // driver tasks
  task automatic drive(input logic v, input logic h, input logic [DW-1:0] d);
    @(negedge clk);
    vsync = v; hsync = h; data = d;
    cap_start = 1'b0; cap_abort = 1'b0;
  endtask

  task automatic set_params(input logic [FW-1:0] n, input logic [3:0] s, input logic [1:0] b);
    cap_num = n; cap_skip = s; sel_base = b;
  endtask

  task automatic start_run(input logic [FW-1:0] n, input logic [3:0] s, input logic [1:0] b);
    set_params(n, s, b);
    drive(0, 0, '0);
    cap_start = 1'b1;
    if (n == '0) push_ev(K_DONE, cyc + 2, 2'd0, '0);
    drive(0, 0, '0);
    check("busy_after_start", 64'(cap_busy), 64'd1);
  endtask

  // One frame: vsync high, 1 idle cycle, nlines lines of H pixels (short_line
  // has H-1) each followed by 2 idle cycles, then vsync low for 4 cycles.
  task automatic gen_frame(input bit cap, input logic [1:0] sel, input int nlines,
                           input int short_line, input bit done, input int abort_line,
                           input int start_line);
    int npix;
    logic [DW-1:0] d;
    frm_id++;
    drive(1, 0, '0);
    if (cap) push_ev(K_RISE, cyc + 1, sel, '0);
    drive(1, 0, '0);
    for (int l = 0; l < nlines; l++) begin
      npix = (l == short_line) ? H - 1 : H;
      for (int p = 0; p < npix; p++) begin
        d = {8'(frm_id), 8'(l), 8'(p + 1)};
        drive(1, 1, d);
        if (l == start_line && p == 0) cap_start = 1'b1;
        if (l == abort_line && p == 0) cap_abort = 1'b1;
        if (cap) push_ev(K_PIX, cyc + 1, sel, d);
      end
      drive(1, 0, '0);
      drive(1, 0, '0);
    end
    drive(0, 0, '0);
    if (cap)  push_ev(K_FALL, cyc + 1, sel, '0);
    if (done) push_ev(K_DONE, cyc + 1, 2'd0, '0);
    repeat (3) drive(0, 0, '0);
  endtask

  task automatic clean_frame(input bit cap, input logic [1:0] sel, input bit done);
    gen_frame(cap, sel, V, -1, done, -1, -1);
  endtask

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("reset_stream", {st_src_sel, st_hsync, st_vsync, st_data}, '0);
    check("reset_status", {cap_busy, cap_done, frm_stored, frm_err, dbg_state}, '0);
    rst_n = 1'b1;
    drive(0, 0, '0);
    check("post_reset_status", {cap_busy, cap_done, frm_stored, frm_err, dbg_state}, '0);

    // 1: two of three clean frames, sel 1 then 2
    start_run(8'd2, 4'd0, 2'd1);
    check("t1_arm_state", 64'(dbg_state), 64'd1);
    clean_frame(1, 2'd1, 0);
    clean_frame(1, 2'd2, 1);
    clean_frame(0, 2'd0, 0);
    check("t1_stored", 64'(frm_stored), 64'd2);
    check("t1_err", 64'(frm_err), 64'd0);
    check("t1_busy", 64'(cap_busy), 64'd0);

    // 4: bad geometry (short line, 3 lines)
    start_run(8'd1, 4'd0, 2'd2);
    gen_frame(1, 2'd2, 3, 1, 1, -1, -1);
    check("t4_err", 64'(frm_err), 64'd3);
    check("t4_stored", 64'(frm_stored), 64'd1);

    // 2: start while a frame is running
    set_params(8'd1, 4'd0, 2'd2);
    gen_frame(0, 2'd0, V, -1, 0, -1, 1);
    check("t2_still_armed", {cap_busy, dbg_state}, {1'b1, 2'd1});
    check("t2_err_cleared", 64'(frm_err), 64'd0);
    clean_frame(1, 2'd2, 1);
    check("t2_stored", 64'(frm_stored), 64'd1);

    // 3: skip 2, sel 3 -> frames 1,4,7 with sel 3,0,1
    start_run(8'd3, 4'd2, 2'd3);
    clean_frame(1, 2'd3, 0);
    check("t3_skip_state", 64'(dbg_state), 64'd2);
    clean_frame(0, 2'd0, 0);
    clean_frame(0, 2'd0, 0);
    clean_frame(1, 2'd0, 0);
    clean_frame(0, 2'd0, 0);
    clean_frame(0, 2'd0, 0);
    clean_frame(1, 2'd1, 1);
    check("t3_stored", 64'(frm_stored), 64'd3);
    check("t3_busy", 64'(cap_busy), 64'd0);

    // 5a: abort during capture completes the frame, no done
    start_run(8'd4, 4'd0, 2'd0);
    gen_frame(1, 2'd0, V, -1, 0, 2, -1);
    check("t5_stored", 64'(frm_stored), 64'd1);
    check("t5_idle", {cap_busy, dbg_state}, {1'b0, 2'd0});
    clean_frame(0, 2'd0, 0);

    // 5b: abort in SKIP takes effect on the next cycle
    start_run(8'd2, 4'd3, 2'd1);
    clean_frame(1, 2'd1, 0);
    check("t5b_skip_state", 64'(dbg_state), 64'd2);
    drive(0, 0, '0);
    cap_abort = 1'b1;
    drive(0, 0, '0);
    check("t5b_idle", {cap_busy, dbg_state}, {1'b0, 2'd0});
    clean_frame(0, 2'd0, 0);
    check("t5b_stored", 64'(frm_stored), 64'd1);

    // abort and start together in IDLE: abort wins
    set_params(8'd1, 4'd0, 2'd0);
    drive(0, 0, '0);
    cap_start = 1'b1;
    cap_abort = 1'b1;
    drive(0, 0, '0);
    check("abort_start_idle", {cap_busy, dbg_state}, {1'b0, 2'd0});
    clean_frame(0, 2'd0, 0);

    // 6: cap_num=0 -> busy one cycle, done the next
    start_run(8'd0, 4'd0, 2'd0);
    drive(0, 0, '0);
    check("t6_busy_one_cycle", 64'(cap_busy), 64'd0);
    check("t6_stored", 64'(frm_stored), 64'd0);
    clean_frame(0, 2'd0, 0);

    repeat (5) drive(0, 0, '0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
